// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Collects the registered per-unit results of the structural ALU. Each cycle
// it looks at the four unit flags. If exactly one is high, the matching result
// is zero-extended to the common result width, tagged with a unit code and
// pushed into a small first-word-fall-through FIFO. A consumer drains the FIFO
// over a valid/ready handshake. Two saturating counters record results that
// were dropped because the FIFO was full (OVF_CNT) and cycles where more than
// one flag was high (ERR_CNT).
//
// Ports
//   CLK, RST                  clock (rising edge), asynchronous active-low reset
//   Arith_OUT/Carry_OUT/Arith_Flag   arithmetic result, carry, valid
//   Logic_OUT/Logic_Flag             logic result, valid
//   CMP_OUT/CMP_Flag                 compare result, valid
//   Shift_OUT/Shift_Flag             shift result, valid
//   RES_DATA/RES_UNIT/RES_CARRY      head entry (all zero while empty)
//   RES_VALID/RES_READY              output handshake
//   FIFO_FULL                        FIFO holds FIFO_DEPTH entries
//   OVF_CNT, ERR_CNT                 saturating drop / flag-error counters
//
// Handshake: RES_VALID is high whenever the FIFO holds an entry and the head
// entry is stable on RES_* until taken. The entry is taken on a rising edge
// where RES_VALID and RES_READY are both high. RES_READY may be high at any
// time; while RES_VALID is low it has no effect.
// -----------------------------------------------------------------------------
module alu_result_fifo #(
   parameter int OP_DATA_WIDTH   = 16,
   parameter int Arith_OUT_WIDTH = 2 * OP_DATA_WIDTH,
   parameter int CMP_OUT_WIDTH   = 2,
   parameter int FIFO_DEPTH      = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [Arith_OUT_WIDTH-1:0] Arith_OUT,
   input  logic                       Carry_OUT,
   input  logic                       Arith_Flag,
   input  logic [OP_DATA_WIDTH-1:0]   Logic_OUT,
   input  logic                       Logic_Flag,
   input  logic [CMP_OUT_WIDTH-1:0]   CMP_OUT,
   input  logic                       CMP_Flag,
   input  logic [OP_DATA_WIDTH-1:0]   Shift_OUT,
   input  logic                       Shift_Flag,
   output logic [Arith_OUT_WIDTH-1:0] RES_DATA,
   output logic [1:0]                 RES_UNIT,
   output logic                       RES_CARRY,
   output logic                       RES_VALID,
   input  logic                       RES_READY,
   output logic                       FIFO_FULL,
   output logic [CNT_WIDTH-1:0]       OVF_CNT,
   output logic [CNT_WIDTH-1:0]       ERR_CNT
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   // Storage and control state
   logic [Arith_OUT_WIDTH-1:0] data_q  [FIFO_DEPTH];
   logic [Arith_OUT_WIDTH-1:0] data_d  [FIFO_DEPTH];
   logic [1:0]                 unit_q  [FIFO_DEPTH];
   logic [1:0]                 unit_d  [FIFO_DEPTH];
   logic                       carry_q [FIFO_DEPTH];
   logic                       carry_d [FIFO_DEPTH];

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]     occ_q, occ_d;
   logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] err_q, err_d;

   // Per-cycle decode
   logic [3:0]                 flags;
   logic                       multi_flag;
   logic                       one_flag;
   logic [Arith_OUT_WIDTH-1:0] entry_data;
   logic [1:0]                 entry_unit;
   logic                       entry_carry;
   logic                       not_empty;
   logic                       is_full;
   logic                       pop;
   logic                       push;
   logic                       drop;

   always_comb begin
      flags      = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
      // Clearing the lowest set bit leaves something only if two or more are set.
      multi_flag = ((flags & (flags - 4'd1)) != 4'd0);
      one_flag   = (flags != 4'd0) && !multi_flag;

      entry_data  = {{(Arith_OUT_WIDTH - OP_DATA_WIDTH){1'b0}}, Shift_OUT};
      entry_unit  = UNIT_SHIFT;
      entry_carry = 1'b0;
      if (Arith_Flag) begin
         entry_data  = Arith_OUT;
         entry_unit  = UNIT_ARITH;
         entry_carry = Carry_OUT;
      end else if (Logic_Flag) begin
         entry_data  = {{(Arith_OUT_WIDTH - OP_DATA_WIDTH){1'b0}}, Logic_OUT};
         entry_unit  = UNIT_LOGIC;
      end else if (CMP_Flag) begin
         entry_data  = {{(Arith_OUT_WIDTH - CMP_OUT_WIDTH){1'b0}}, CMP_OUT};
         entry_unit  = UNIT_CMP;
      end
   end

   always_comb begin
      not_empty = (occ_q != '0);
      is_full   = (occ_q == OCC_FULL);
      pop       = not_empty && RES_READY;
      // A full FIFO still accepts a write when the head leaves in the same cycle.
      push      = one_flag && (!is_full || pop);
      drop      = one_flag && is_full && !pop;
   end

   always_comb begin
      data_d   = data_q;
      unit_d   = unit_q;
      carry_d  = carry_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      ovf_d    = ovf_q;
      err_d    = err_q;

      if (push) begin
         data_d[wr_ptr_q]  = entry_data;
         unit_d[wr_ptr_q]  = entry_unit;
         carry_d[wr_ptr_q] = entry_carry;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - OCC_W'(1);
      end

      if (drop && (ovf_q != '1)) begin
         ovf_d = ovf_q + CNT_WIDTH'(1);
      end
      if (multi_flag && (err_q != '1)) begin
         err_d = err_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i]  <= '0;
            unit_q[i]  <= '0;
            carry_q[i] <= 1'b0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ovf_q    <= '0;
         err_q    <= '0;
      end else begin
         data_q   <= data_d;
         unit_q   <= unit_d;
         carry_q  <= carry_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   // Head entry falls through from storage; forced to zero while empty so
   // stale slots never leak onto the outputs.
   always_comb begin
      RES_VALID = not_empty;
      FIFO_FULL = is_full;
      RES_DATA  = not_empty ? data_q[rd_ptr_q]  : '0;
      RES_UNIT  = not_empty ? unit_q[rd_ptr_q]  : 2'b00;
      RES_CARRY = not_empty ? carry_q[rd_ptr_q] : 1'b0;
      OVF_CNT   = ovf_q;
      ERR_CNT   = err_q;
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] Arith_OUT = '0;
   logic        Carry_OUT = 1'b0;
   logic        Arith_Flag = 1'b0;
   logic [15:0] Logic_OUT = '0;
   logic        Logic_Flag = 1'b0;
   logic [1:0]  CMP_OUT = '0;
   logic        CMP_Flag = 1'b0;
   logic [15:0] Shift_OUT = '0;
   logic        Shift_Flag = 1'b0;
   logic [31:0] RES_DATA;
   logic [1:0]  RES_UNIT;
   logic        RES_CARRY;
   logic        RES_VALID;
   logic        RES_READY = 1'b0;
   logic        FIFO_FULL;
   logic [7:0]  OVF_CNT;
   logic [7:0]  ERR_CNT;

   alu_result_fifo dut (
      .CLK(CLK), .RST(RST),
      .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
      .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
      .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
      .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
      .RES_DATA(RES_DATA), .RES_UNIT(RES_UNIT), .RES_CARRY(RES_CARRY),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .FIFO_FULL(FIFO_FULL),
      .OVF_CNT(OVF_CNT), .ERR_CNT(ERR_CNT)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard / model ----------------
   // Entry packing: {carry, unit[1:0], data[31:0]}
   logic [34:0] exp_q[$];
   int          mdl_ovf = 0;
   int          mdl_err = 0;
   int          n_pass  = 0;
   int          n_total = 0;

   int          m_ones;
   logic        m_pop;
   logic [34:0] m_entry;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         exp_q.delete();
         mdl_ovf = 0;
         mdl_err = 0;
      end else begin
         m_ones = $countones({Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag});
         m_pop  = (exp_q.size() > 0) && RES_READY;
         if (Arith_Flag)      m_entry = {Carry_OUT, 2'b00, Arith_OUT};
         else if (Logic_Flag) m_entry = {1'b0, 2'b01, 16'h0000, Logic_OUT};
         else if (CMP_Flag)   m_entry = {1'b0, 2'b10, 30'h0, CMP_OUT};
         else                 m_entry = {1'b0, 2'b11, 16'h0000, Shift_OUT};
         if (m_pop) void'(exp_q.pop_front());
         if (m_ones > 1) begin
            if (mdl_err < 255) mdl_err++;
         end else if (m_ones == 1) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(m_entry);
            else if (mdl_ovf < 255) mdl_ovf++;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge CLK) begin
      chk("valid", 64'(RES_VALID), 64'(exp_q.size() != 0));
      chk("full",  64'(FIFO_FULL), 64'(exp_q.size() == DEPTH));
      chk("ovf",   64'(OVF_CNT),   64'(mdl_ovf));
      chk("err",   64'(ERR_CNT),   64'(mdl_err));
      if (exp_q.size() != 0) begin
         chk("data",  64'(RES_DATA),  64'(exp_q[0][31:0]));
         chk("unit",  64'(RES_UNIT),  64'(exp_q[0][33:32]));
         chk("carry", 64'(RES_CARRY), 64'(exp_q[0][34]));
      end else begin
         chk("data_empty", 64'({RES_CARRY, RES_UNIT, RES_DATA}), 64'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; Shift_Flag = 1'b0;
   endtask

   task automatic push_arith(input logic [31:0] d, input logic c);
      idle(); Arith_OUT = d; Carry_OUT = c; Arith_Flag = 1'b1; step(); idle();
   endtask

   task automatic push_logic(input logic [15:0] d);
      idle(); Logic_OUT = d; Logic_Flag = 1'b1; step(); idle();
   endtask

   task automatic push_cmp(input logic [1:0] d);
      idle(); CMP_OUT = d; CMP_Flag = 1'b1; step(); idle();
   endtask

   task automatic push_shift(input logic [15:0] d);
      idle(); Shift_OUT = d; Shift_Flag = 1'b1; step(); idle();
   endtask

   task automatic chk_head(input string name, input logic [31:0] d, input logic [1:0] u, input logic c);
      chk({name, "_valid"}, 64'(RES_VALID), 64'd1);
      chk({name, "_data"},  64'(RES_DATA),  64'(d));
      chk({name, "_unit"},  64'(RES_UNIT),  64'(u));
      chk({name, "_carry"}, 64'(RES_CARRY), 64'(c));
   endtask

   // ---------------- directed stimulus ----------------
   logic [31:0] exp_d [4];
   logic [1:0]  exp_u [4];
   logic        exp_c [4];

   initial begin
      // Reset state
      #12;
      chk("rst_valid", 64'(RES_VALID), 64'd0);
      chk("rst_full",  64'(FIFO_FULL), 64'd0);
      chk("rst_cnts",  64'({OVF_CNT, ERR_CNT}), 64'd0);
      RST = 1'b1;
      step();

      // Single arith entry, one-cycle latency, popped next edge
      RES_READY = 1'b1;
      push_arith(32'hFFFF_FFF7, 1'b0);
      chk_head("t1", 32'hFFFF_FFF7, 2'b00, 1'b0);
      step();
      chk("t1_popped", 64'(RES_VALID), 64'd0);

      // Fill with one of each unit, then drain in order
      RES_READY = 1'b0;
      push_logic(16'hFFFE);
      push_cmp(2'd2);
      push_shift(16'h0014);
      push_arith(32'h0001_FFFE, 1'b1);
      chk("t2_full", 64'(FIFO_FULL), 64'd1);
      exp_d = '{32'h0000_FFFE, 32'h0000_0002, 32'h0000_0014, 32'h0001_FFFE};
      exp_u = '{2'b01, 2'b10, 2'b11, 2'b00};
      exp_c = '{1'b0, 1'b0, 1'b0, 1'b1};
      RES_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_head($sformatf("t2_pop%0d", i), exp_d[i], exp_u[i], exp_c[i]);
         step();
      end
      chk("t2_empty", 64'(RES_VALID), 64'd0);

      // Overflow while full, then a full write with simultaneous pop
      RES_READY = 1'b0;
      for (int i = 1; i <= 4; i++) push_shift(16'(i * 16'h0011));
      for (int i = 0; i < 3; i++) push_logic(16'h0001);
      chk("t3_ovf", 64'(OVF_CNT), 64'd3);
      chk_head("t3_head", 32'h0000_0011, 2'b11, 1'b0);
      RES_READY = 1'b1;
      push_logic(16'h0001);
      chk("t3_ovf_hold", 64'(OVF_CNT), 64'd3);
      chk("t3_full_hold", 64'(FIFO_FULL), 64'd1);
      chk_head("t3_newhead", 32'h0000_0022, 2'b11, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("t3_drained", 64'(RES_VALID), 64'd0);

      // Multiple flags: error count, nothing written, saturation
      RES_READY = 1'b0;
      Arith_Flag = 1'b1; Logic_Flag = 1'b1;
      step(); step();
      chk("t4_err2", 64'(ERR_CNT), 64'd2);
      chk("t4_novalid", 64'(RES_VALID), 64'd0);
      for (int i = 0; i < 300; i++) step();
      chk("t4_err_sat", 64'(ERR_CNT), 64'd255);
      idle();

      // Asynchronous reset mid-cycle with two entries stored
      push_shift(16'h0005);
      push_shift(16'h0006);
      chk("t5_pre_valid", 64'(RES_VALID), 64'd1);
      #3;
      RST = 1'b0;
      #1;
      chk("t5_valid", 64'(RES_VALID), 64'd0);
      chk("t5_full",  64'(FIFO_FULL), 64'd0);
      chk("t5_ovf",   64'(OVF_CNT),   64'd0);
      chk("t5_err",   64'(ERR_CNT),   64'd0);
      #2;
      RST = 1'b1;
      step(); step(); step();
      chk("t5_after", 64'(RES_VALID), 64'd0);

      // Streaming push+pop with pointer wrap
      RES_READY = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         push_shift(16'(i));
         chk_head($sformatf("t6_%0d", i), 32'(i), 2'b11, 1'b0);
         chk($sformatf("t6_full%0d", i), 64'(FIFO_FULL), 64'd0);
      end
      step();
      chk("t6_empty", 64'(RES_VALID), 64'd0);

      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the structural ALU top. Each cycle it consumes the registered per-unit results and one-hot unit flags, selects the active unit's result, and zero-extends it to a common result word.
- It tags the result with a unit code, buffers it in a small FIFO, and presents it to a consumer over a valid/ready handshake.
- It tracks dropped results (overflow) and flag one-hot violations in saturating counters.

Parameters:
- OP_DATA_WIDTH, 16, operand width; logic and shift result width.
- Arith_OUT_WIDTH, 2*OP_DATA_WIDTH, arithmetic result width; also the RES_DATA width.
- CMP_OUT_WIDTH, 2, compare result width.
- FIFO_DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 8, width of the overflow and error counters.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous active-low reset.
- Arith_OUT  in  Arith_OUT_WIDTH  arithmetic unit result, signed.
- Carry_OUT  in  1  arithmetic carry.
- Arith_Flag  in  1  arithmetic result valid this cycle.
- Logic_OUT  in  OP_DATA_WIDTH  logic unit result.
- Logic_Flag  in  1  logic result valid.
- CMP_OUT  in  CMP_OUT_WIDTH  compare unit result.
- CMP_Flag  in  1  compare result valid.
- Shift_OUT  in  OP_DATA_WIDTH  shift unit result.
- Shift_Flag  in  1  shift result valid.
- RES_DATA  out  Arith_OUT_WIDTH  head entry data.
- RES_UNIT  out  2  head entry unit code: 00 arith, 01 logic, 10 cmp, 11 shift.
- RES_CARRY  out  1  head entry carry; 0 for non-arith entries.
- RES_VALID  out  1  FIFO not empty.
- RES_READY  in  1  consumer accepts the head entry.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries.
- OVF_CNT  out  CNT_WIDTH  results dropped because the FIFO was full.
- ERR_CNT  out  CNT_WIDTH  cycles with more than one flag high.

Behaviour:
- Reset (RST=0, asynchronous): write/read pointers and occupancy cleared, RES_VALID=0, FIFO_FULL=0, OVF_CNT=0, ERR_CNT=0. RES_DATA, RES_UNIT and RES_CARRY read 0 while empty. Reset mid-stream discards all stored entries; no entry is emitted after release until a new capture.
- Flag decode, per cycle, combinational on the inputs:
  - exactly one flag high: capture request.
  - no flag high: idle, nothing written.
  - two or more flags high: nothing written; ERR_CNT +1.
- Data formation:
  - Arith: Arith_OUT passed unchanged; carry = Carry_OUT.
  - Logic and Shift: zero-extended to Arith_OUT_WIDTH; carry = 0.
  - CMP: zero-extended; carry = 0.
- Write: on capture request with FIFO not full, the entry is stored at the write pointer and the pointer increments, wrapping at FIFO_DEPTH.
- Full write: if FIFO full and a pop occurs in the same cycle, the write is accepted (occupancy unchanged). If full and no pop, the entry is dropped and OVF_CNT +1.
- Read: first-word-fall-through. RES_DATA/RES_UNIT/RES_CARRY show the head entry combinationally from storage. A pop occurs when RES_VALID=1 and RES_READY=1 on the rising edge; the read pointer increments with wrap. RES_READY while empty is ignored.
- Latency: an entry captured at edge N is visible on RES_* with RES_VALID=1 after edge N, i.e. one cycle after the flag cycle. The FIFO does not bypass while empty.
- Simultaneous push and pop: occupancy unchanged. When occupancy is 1, the head is popped and the new entry becomes the head next cycle.
- Occupancy counter: 0..FIFO_DEPTH. FIFO_FULL = (occupancy == FIFO_DEPTH), registered-equivalent.
- Counters: saturate at all-ones and never wrap. A cycle can increment ERR_CNT or OVF_CNT, never both (an error cycle writes nothing).
- Entry ordering is strictly FIFO; no entry is ever duplicated or reordered.

Test Plan:
- Reset then Arith_Flag=1, Arith_OUT=-9 (32'hFFFFFFF7), Carry_OUT=0, RES_READY=1 -> next cycle RES_VALID=1, RES_DATA=32'hFFFFFFF7, RES_UNIT=00, RES_CARRY=0; popped the following edge, RES_VALID=0.
- RES_READY=0; push Logic 16'hFFFE, CMP 2'd2, Shift 16'h0014, Arith 32'h1FFFE with carry 1 -> FIFO_FULL=1. Then raise RES_READY -> pops in order: (0000FFFE,01,0), (00000002,10,0), (00000014,11,0), (0001FFFE,00,1).
- FIFO full, RES_READY=0, push Logic 16'h0001 three times -> OVF_CNT=3, contents unchanged. Then full with RES_READY=1 and a push in the same cycle -> accepted, OVF_CNT stays 3, FIFO_FULL stays 1.
- Arith_Flag=1 and Logic_Flag=1 together for 2 cycles -> ERR_CNT=2, RES_VALID stays 0. Force the error condition 300 cycles -> ERR_CNT=255.
- 2 entries stored, assert RST=0 mid-cycle -> RES_VALID, FIFO_FULL, OVF_CNT, ERR_CNT go to 0 immediately (asynchronously); after release with all flags low, RES_VALID stays 0.
- Continuous push and pop for 10 cycles with Shift values 1..10 -> output sequence 1..10 with one-cycle lag; pointers wrap without loss; FIFO_FULL never asserts.
